// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with valid/ready handshake and a 2-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic [CNT_W-1:0] illegal_cnt
);
  localparam logic [2:0] T_NONE = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                         T_U = 3'd4, T_J = 3'd5, T_SH = 3'd6, T_ILL = 3'd7;
  logic [6:0] op;
  logic [2:0] f3;
  logic signed [11:0] i_imm, s_imm;
  logic signed [12:0] b_imm;
  logic signed [20:0] j_imm;
  logic signed [31:0] u_imm;
  logic [5:0] shamt;
  logic [XLEN-1:0] imm_d;
  logic [2:0] type_d;
  logic acc;
  logic skid_valid;
  logic [XLEN-1:0] skid_imm;
  logic [2:0] skid_type;
  logic [TAG_W-1:0] skid_tag;
  assign op    = in_instr[6:0];
  assign f3    = in_instr[14:12];
  assign i_imm = in_instr[31:20];
  assign s_imm = {in_instr[31:25], in_instr[11:7]};
  assign b_imm = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign j_imm = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign u_imm = {in_instr[31:12], 12'b0};
  assign shamt = XLEN == 64 ? in_instr[25:20] : {1'b0, in_instr[24:20]};
  // Opcodes outside the table (including any with instr[1:0] != 2'b11) fall through as ILLEGAL.
  always_comb begin
    type_d = T_ILL;
    imm_d  = '0;
    case (op)
      7'b0000011, 7'b0001111, 7'b1100111, 7'b1110011: begin
        type_d = T_I;
        imm_d  = XLEN'(i_imm);
      end
      7'b0010011: begin
        type_d = (f3 == 3'b001 || f3 == 3'b101) ? T_SH : T_I;
        imm_d  = (f3 == 3'b001 || f3 == 3'b101) ? XLEN'(shamt) : XLEN'(i_imm);
      end
      7'b0011011: begin
        type_d = XLEN == 64 ? T_I : T_ILL;
        imm_d  = XLEN == 64 ? XLEN'(i_imm) : '0;
      end
      7'b0100011: begin
        type_d = T_S;
        imm_d  = XLEN'(s_imm);
      end
      7'b1100011: begin
        type_d = T_B;
        imm_d  = XLEN'(b_imm);
      end
      7'b0110111, 7'b0010111: begin
        type_d = T_U;
        imm_d  = XLEN'(u_imm);
      end
      7'b1101111: begin
        type_d = T_J;
        imm_d  = XLEN'(j_imm);
      end
      7'b0110011: type_d = T_NONE;
      7'b0111011: type_d = XLEN == 64 ? T_NONE : T_ILL;
      default: type_d = T_ILL;
    endcase
  end
  assign in_ready = !skid_valid;
  assign acc      = in_valid && in_ready;
  // The skid entry is only ever filled while the output register is full and stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_imm     <= '0;
      out_type    <= '0;
      out_tag     <= '0;
      skid_valid  <= 1'b0;
      skid_imm    <= '0;
      skid_type   <= '0;
      skid_tag    <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (!out_valid || out_ready) begin
        out_valid <= skid_valid || acc;
        if (skid_valid) begin
          out_imm    <= skid_imm;
          out_type   <= skid_type;
          out_tag    <= skid_tag;
          skid_valid <= 1'b0;
        end else if (acc) begin
          out_imm  <= imm_d;
          out_type <= type_d;
          out_tag  <= in_tag;
        end
      end else if (acc) begin
        skid_imm   <= imm_d;
        skid_type  <= type_d;
        skid_tag   <= in_tag;
        skid_valid <= 1'b1;
      end
      if (acc && type_d == T_ILL && !(&illegal_cnt))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and random checks of two imm_gen_pipe instances (RV32 and RV64/CNT_W=2) against a FIFO reference model.
module tb_imm_gen_pipe;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0, in_tag = 0;
  logic r32, v32, r64, v64;
  logic [31:0] imm32, tag32, tag64;
  logic [63:0] imm64;
  logic [2:0] ty32, ty64;
  logic [15:0] cnt32;
  logic [1:0] cnt64;
  int ncmp = 0, nbad = 0, mc32 = 0, mc64 = 0;
  typedef struct {logic [63:0] i32; logic [2:0] t32; logic [63:0] i64; logic [2:0] t64; logic [31:0] tag;} ent_t;
  ent_t q[$];

  imm_gen_pipe u32 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_tag(in_tag), .out_valid(v32), .out_ready(out_ready), .out_imm(imm32),
    .out_type(ty32), .out_tag(tag32), .illegal_cnt(cnt32));
  imm_gen_pipe #(.XLEN(64), .CNT_W(2)) u64 (.clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
    .in_ready(r64), .in_instr(in_instr), .in_tag(in_tag), .out_valid(v64), .out_ready(out_ready),
    .out_imm(imm64), .out_type(ty64), .out_tag(tag64), .illegal_cnt(cnt64));

  always #5 clk = ~clk;

  task automatic chk(input string tg, input logic [63:0] o, input logic [63:0] e);
    ncmp++;
    assert (o === e) else begin
      nbad++;
      $error("FAIL %s: observed %h expected %h", tg, o, e);
    end
  endtask

  // Reference decode: place each field at the top of a 64-bit word and arithmetic-shift it down.
  function automatic void ref_dec(input logic [31:0] i, input int xl, output logic [63:0] imm, output logic [2:0] ty);
    int op = int'(i[6:0]);
    int f3 = int'(i[14:12]);
    ty = 7;
    imm = 0;
    if (op == 3 || op == 15 || op == 19 || op == 103 || op == 115 || (xl == 64 && op == 27)) begin
      ty = 1;
      imm = $signed({i[31:20], 52'b0}) >>> 52;
    end
    if (op == 19 && (f3 == 1 || f3 == 5)) begin
      ty = 6;
      imm = xl == 64 ? 64'(i[25:20]) : 64'(i[24:20]);
    end
    if (op == 35) begin
      ty = 2;
      imm = $signed({i[31:25], i[11:7], 52'b0}) >>> 52;
    end
    if (op == 99) begin
      ty = 3;
      imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0, 51'b0}) >>> 51;
    end
    if (op == 55 || op == 23) begin
      ty = 4;
      imm = $signed({i[31:12], 44'b0}) >>> 32;
    end
    if (op == 111) begin
      ty = 5;
      imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0, 43'b0}) >>> 43;
    end
    if (op == 51 || (xl == 64 && op == 59)) ty = 0;
    if (xl == 32) imm = imm & 64'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rnd_instr();
    int ops[13] = '{3, 15, 19, 103, 115, 27, 35, 99, 55, 23, 111, 51, 59};
    logic [31:0] r = $urandom;
    int s = int'($urandom_range(0, 15));
    if (s < 13) r[6:0] = 7'(ops[s]);
    return r;
  endfunction

  task automatic check();
    chk("in_ready32", r32, q.size() < 2);
    chk("in_ready64", r64, q.size() < 2);
    chk("out_valid32", v32, q.size() > 0);
    chk("out_valid64", v64, q.size() > 0);
    chk("cnt32", cnt32, mc32);
    chk("cnt64", cnt64, mc64);
    if (q.size() > 0) begin
      chk("imm32", imm32, q[0].i32);
      chk("type32", ty32, q[0].t32);
      chk("tag32", tag32, q[0].tag);
      chk("imm64", imm64, q[0].i64);
      chk("type64", ty64, q[0].t64);
      chk("tag64", tag64, q[0].tag);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] tg, input logic ordy, input logic fl);
    logic acc, xf;
    ent_t e;
    in_valid = v;
    in_instr = ins;
    in_tag = tg;
    out_ready = ordy;
    flush = fl;
    acc = v && q.size() < 2;
    xf = ordy && q.size() > 0;
    @(posedge clk);
    if (fl) q.delete();
    else begin
      if (xf) void'(q.pop_front());
      if (acc) begin
        ref_dec(ins, 32, e.i32, e.t32);
        ref_dec(ins, 64, e.i64, e.t64);
        e.tag = tg;
        q.push_back(e);
        if (e.t32 == 7) mc32++;
        if (e.t64 == 7 && mc64 < 3) mc64++;
      end
    end
    @(negedge clk);
    check();
  endtask

  task automatic chk_reset();
    chk("rst_v32", v32, 0);
    chk("rst_r32", r32, 1);
    chk("rst_imm32", imm32, 0);
    chk("rst_ty32", ty32, 0);
    chk("rst_tag32", tag32, 0);
    chk("rst_cnt32", cnt32, 0);
    chk("rst_v64", v64, 0);
    chk("rst_r64", r64, 1);
    chk("rst_imm64", imm64, 0);
    chk("rst_cnt64", cnt64, 0);
  endtask

  initial begin
    logic [31:0] sv[4] = '{32'h0020A1A3, 32'hFE000EE3, 32'h0010006F, 32'h12345037};
    logic [31:0] se[4] = '{32'h3, 32'hFFFFFFFC, 32'h800, 32'h12345000};
    logic [2:0] st[4] = '{3'd2, 3'd3, 3'd5, 3'd4};
    repeat (2) @(negedge clk);
    chk_reset();
    rst_n = 1;
    step(1, 32'hFFF00013, 32'h100, 1, 0);
    chk("i_imm", imm32, 32'hFFFFFFFF);
    chk("i_type", ty32, 1);
    chk("i_tag", tag32, 32'h100);
    for (int k = 0; k < 4; k++) begin
      step(1, sv[k], 32'h200 + k, 1, 0);
      chk("stream_imm", imm32, se[k]);
      chk("stream_type", ty32, st[k]);
    end
    step(1, 32'h4030D093, 32'h300, 1, 0);
    chk("shamt_imm", imm32, 3);
    chk("shamt_type", ty32, 6);
    step(1, 32'h80000037, 32'h301, 1, 0);
    chk("u64_imm", imm64, 64'hFFFFFFFF80000000);
    chk("u64_type", ty64, 4);
    step(0, 0, 0, 1, 0);
    // Backpressure: A and B buffered, C held until space frees up.
    step(1, 32'h00100093, 32'hA, 0, 0);
    step(1, 32'h00200113, 32'hB, 0, 0);
    chk("bp_ready", r32, 0);
    step(1, 32'h00300193, 32'hC, 0, 0);
    chk("bp_hold_tag", tag32, 32'hA);
    step(1, 32'h00300193, 32'hC, 1, 0);
    chk("bp_tagB", tag32, 32'hB);
    step(1, 32'h00300193, 32'hC, 1, 0);
    chk("bp_tagC", tag32, 32'hC);
    step(0, 0, 0, 1, 0);
    step(1, 32'h0000007F, 32'h400, 1, 0);
    step(1, 32'h00000012, 32'h401, 1, 0);
    chk("ill_type", ty32, 7);
    chk("ill_imm", imm32, 0);
    chk("ill_cnt", cnt32, 2);
    for (int k = 0; k < 3; k++) step(1, 32'h0000007F, 32'h402 + k, 1, 0);
    chk("ill_sat64", cnt64, 3);
    chk("ill_cnt5", cnt32, 5);
    step(1, 32'h00100093, 32'h500, 0, 0);
    step(1, 32'h00200113, 32'h501, 0, 0);
    step(1, 32'h0000007F, 32'h502, 0, 1);
    chk("flush_valid", v32, 0);
    chk("flush_ready", r32, 1);
    chk("flush_cnt", cnt32, 5);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 31) == 0);
    step(1, rnd_instr(), 32'h600, 0, 0);
    step(1, rnd_instr(), 32'h601, 0, 0);
    #2 rst_n = 0;
    #1 chk_reset();
    q.delete();
    mc32 = 0;
    mc64 = 0;
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 50; k++)
      step($urandom_range(0, 3) != 0, rnd_instr(), $urandom, $urandom_range(0, 2) != 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
